// File: rtl/udp_tx_arbiter.sv
// udp_tx_arbiter: round-robin, packet-locked merge of N UDP TX requesters onto one metadata+data stream
module udp_tx_arbiter #(
  parameter int NUM_PORTS  = 4,
  parameter int WIDTH      = 512,
  parameter int META_WIDTH = 176
) (
  input  logic                            net_clk,
  input  logic                            net_areset,
  input  logic [NUM_PORTS-1:0]            s_meta_valid,
  output logic [NUM_PORTS-1:0]            s_meta_ready,
  input  logic [NUM_PORTS*META_WIDTH-1:0] s_meta_data,
  input  logic [NUM_PORTS-1:0]            s_data_valid,
  output logic [NUM_PORTS-1:0]            s_data_ready,
  input  logic [NUM_PORTS-1:0]            s_data_last,
  input  logic [NUM_PORTS*WIDTH-1:0]      s_data_data,
  input  logic [NUM_PORTS*WIDTH/8-1:0]    s_data_keep,
  output logic                            m_meta_valid,
  input  logic                            m_meta_ready,
  output logic [META_WIDTH-1:0]           m_meta_data,
  output logic                            m_data_valid,
  input  logic                            m_data_ready,
  output logic [WIDTH-1:0]                m_data_data,
  output logic [WIDTH/8-1:0]              m_data_keep,
  output logic                            m_data_last,
  output logic [2:0]                      grant_id,
  output logic                            busy,
  output logic [31:0]                     pkt_count
);
  localparam int GW = $clog2(NUM_PORTS);
  typedef enum logic [1:0] {IDLE, META, DATA} state_t;
  state_t             state_q;
  logic [GW-1:0]      grant_q, grant_d, rr_q, rr_d;
  logic [31:0]        cnt_q;
  logic [NUM_PORTS-1:0] rot, onehot;
  logic [GW:0]        sum;
  logic               meta_hs, last_hs;
  // rotate requests so bit 0 is rr_q, take the lowest set bit, then undo the rotation
  always_comb begin
    rot = NUM_PORTS'({s_meta_valid, s_meta_valid} >> rr_q);
    sum = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--) sum = rot[k] ? (GW+1)'(k) : sum;
    sum = sum + {1'b0, rr_q};
    grant_d = (sum >= (GW+1)'(NUM_PORTS)) ? GW'(sum - (GW+1)'(NUM_PORTS)) : GW'(sum);
  end
  assign rr_d         = (grant_q == GW'(NUM_PORTS - 1)) ? '0 : grant_q + GW'(1);
  assign onehot       = NUM_PORTS'(1) << grant_q;
  assign busy         = state_q != IDLE;
  assign grant_id     = 3'(grant_q);
  assign pkt_count    = cnt_q;
  assign m_meta_valid = (state_q == META) && s_meta_valid[grant_q];
  assign m_meta_data  = s_meta_data[int'(grant_q)*META_WIDTH +: META_WIDTH];
  assign s_meta_ready = (state_q == META && m_meta_ready) ? onehot : '0;
  assign m_data_valid = (state_q == DATA) && s_data_valid[grant_q];
  assign m_data_data  = s_data_data[int'(grant_q)*WIDTH +: WIDTH];
  assign m_data_keep  = s_data_keep[int'(grant_q)*(WIDTH/8) +: WIDTH/8];
  assign m_data_last  = s_data_last[grant_q];
  assign s_data_ready = (state_q == DATA && m_data_ready) ? onehot : '0;
  assign meta_hs      = m_meta_valid && m_meta_ready;
  assign last_hs      = m_data_valid && m_data_ready && m_data_last;
  // lock a requester for a whole packet; the IDLE bubble is where the next grant is chosen
  always_ff @(posedge net_clk or posedge net_areset)
    if (net_areset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      cnt_q   <= '0;
    end else
      case (state_q)
        IDLE: if (|s_meta_valid) begin
          grant_q <= grant_d;
          state_q <= META;
        end
        META: if (meta_hs) state_q <= DATA;
        DATA: if (last_hs) begin
          cnt_q   <= cnt_q + 32'd1;
          rr_q    <= rr_d;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
endmodule
